// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet-5 accelerator: layer indices, layer count
// and the one-hot scheduler state encoding.
package lenet_pkg;

    localparam int N_LAYERS = 4;

    localparam logic [2:0] L_CONV1 = 3'd0;
    localparam logic [2:0] L_CONV2 = 3'd1;
    localparam logic [2:0] L_FC1   = 3'd2;
    localparam logic [2:0] L_FC2   = 3'd3;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_RUN     = 6'b000010,
        S_RELEASE = 6'b000100,
        S_GAP     = 6'b001000,
        S_FINISH  = 6'b010000,
        S_ERROR   = 6'b100000
    } sched_state_t;

    function automatic logic state_is_busy(sched_state_t s);
        return (s == S_RUN) || (s == S_RELEASE) || (s == S_GAP);
    endfunction

endpackage

// File: rtl/lenet_layer_watchdog.sv
// Per-layer watchdog: counts cycles while enabled, held at zero while cleared,
// and flags a timeout on the last allowed cycle.
module lenet_layer_watchdog #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt_reg <= '0;
        end else if (count_en && cnt_reg != LIMIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign timeout = count_en && (cnt_reg == LIMIT);

endmodule

// File: rtl/lenet_layer_scheduler.sv
// Top-level layer sequencer: steps the layer wrappers in order, drives the
// ping-pong bank selects and run-cycle counter. Optional watchdog: SCHED_TIMEOUT_EN.
module lenet_layer_scheduler
    import lenet_pkg::*;
#(
    parameter int N_LAYERS       = lenet_pkg::N_LAYERS,
    parameter int GAP_CYCLES     = 2,
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [N_LAYERS-1:0] layer_en,
    input  logic [N_LAYERS-1:0] layer_done,
    output logic [2:0]          cur_layer,
    output logic                wr_bank_sel,
    output logic                rd_bank_sel,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    cycle_cnt
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [2:0] LAST_LAYER = 3'(N_LAYERS - 1);

    sched_state_t        state_reg, state_next;
    logic [2:0]          cur_reg, cur_next;
    logic [GAP_W-1:0]    gap_reg, gap_next;
    logic [N_LAYERS-1:0] en_reg, en_next;
    logic                busy_reg, done_reg, wr_reg, rd_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [7:0]          done_vec;
    logic                timeout;

    // Widen layer_done to the full 3-bit index range so cur_reg can index it safely.
    for (genvar gi = 0; gi < 8; gi++) begin : g_done_vec
        if (gi < N_LAYERS) begin : g_used
            assign done_vec[gi] = layer_done[gi];
        end else begin : g_unused
            assign done_vec[gi] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_en
        assign en_next[gi] = (state_next == S_RUN) && (cur_next == 3'(gi));
    end

`ifdef SCHED_TIMEOUT_EN
    logic err_reg;

    lenet_layer_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg != S_RUN),
        .count_en(state_reg == S_RUN),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_next == S_ERROR);
        end
    end

    assign err = err_reg;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        gap_next   = gap_reg;
        if (abort && state_reg != S_IDLE) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_next = S_RUN;
                        cur_next   = L_CONV1;
                    end
                end
                S_RUN: begin
                    if (done_vec[cur_reg]) begin
                        state_next = S_RELEASE;
                    end else if (timeout) begin
                        state_next = S_ERROR;
                    end
                end
                S_RELEASE: begin
                    // Wait for the wrapper to leave DONE before moving on.
                    if (!done_vec[cur_reg]) begin
                        state_next = S_GAP;
                        gap_next   = GAP_W'(GAP_CYCLES - 1);
                    end
                end
                S_GAP: begin
                    if (gap_reg == '0) begin
                        if (cur_reg == LAST_LAYER) begin
                            state_next = S_FINISH;
                        end else begin
                            state_next = S_RUN;
                            cur_next   = cur_reg + 3'd1;
                        end
                    end else begin
                        gap_next = gap_reg - 1'b1;
                    end
                end
                S_FINISH: state_next = S_IDLE;
                S_ERROR:  state_next = S_ERROR;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cur_reg   <= L_CONV1;
            gap_reg   <= '0;
            en_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            wr_reg    <= 1'b0;
            rd_reg    <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            gap_reg   <= gap_next;
            en_reg    <= en_next;
            busy_reg  <= state_is_busy(state_next);
            done_reg  <= (state_next == S_FINISH);
            wr_reg    <= cur_next[0];
            rd_reg    <= ~cur_next[0];
            if (state_reg == S_IDLE && state_next == S_RUN) begin
                cnt_reg <= '0;
            end else if (busy_reg && cnt_reg != '1) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign layer_en    = en_reg;
    assign cur_layer   = cur_reg;
    assign wr_bank_sel = wr_reg;
    assign rd_bank_sel = rd_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign cycle_cnt   = cnt_reg;

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// Directed bench for lenet_layer_scheduler with behavioural layer-wrapper models.
// Build with SCHED_TIMEOUT_EN defined to exercise the watchdog path.
module tb_lenet_layer_scheduler;

    localparam int LAT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  layer_en;
    logic [3:0]  layer_done;
    logic [2:0]  cur_layer;
    logic        wr_bank_sel, rd_bank_sel, busy, done, err;
    logic [23:0] cycle_cnt;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    int ws [4];
    int wc [4];
    logic [3:0] wdone;
    logic [3:0] spur_mask = 4'b0000;
    logic       hang = 1'b0;

    always #5 clk = ~clk;

    lenet_layer_scheduler #(
        .N_LAYERS(4), .GAP_CYCLES(2), .CNT_W(24), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_en(layer_en), .layer_done(layer_done), .cur_layer(cur_layer),
        .wr_bank_sel(wr_bank_sel), .rd_bank_sel(rd_bank_sel),
        .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt)
    );

    // Wrapper model: IDLE(0) -> BUSY(1) on en, DONE(2) LAT cycles after en rose, IDLE when en drops.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            case (ws[i])
                0: if (layer_en[i]) begin ws[i] <= 1; wc[i] <= 1; end
                1: begin
                    if (!layer_en[i]) ws[i] <= 0;
                    else if (wc[i] == LAT - 1 && !hang) ws[i] <= 2;
                    else wc[i] <= wc[i] + 1;
                end
                default: if (!layer_en[i]) ws[i] <= 0;
            endcase
        end
        if (done) done_pulses <= done_pulses + 1;
    end

    always_comb begin
        wdone = 4'b0000;
        for (int i = 0; i < 4; i++) wdone[i] = (ws[i] == 2);
    end
    assign layer_done = wdone | spur_mask;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_en(input logic [3:0] mask, input int bound);
        int n = 0;
        while (layer_en !== mask && n < bound) begin
            tick();
            n++;
        end
        check("wait_layer_en", {28'd0, layer_en}, {28'd0, mask});
    endtask

    initial begin
        int n;
        int pulses_before;
        for (int i = 0; i < 4; i++) begin ws[i] = 0; wc[i] = 0; end

        // Reset state
        repeat (3) tick();
        check("rst_en", {28'd0, layer_en}, 32'h0);
        check("rst_cur", {29'd0, cur_layer}, 32'h0);
        check("rst_wr", {31'd0, wr_bank_sel}, 32'h0);
        check("rst_rd", {31'd0, rd_bank_sel}, 32'h1);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
        check("rst_err", {31'd0, err}, 32'h0);
        check("rst_cnt", {8'd0, cycle_cnt}, 32'h0);
        rst = 1'b1;
        tick();

        // Nominal run with a spurious done from layer 2 during layer 0
        pulse_start();
        check("run0_en", {28'd0, layer_en}, 32'h1);
        check("run0_busy", {31'd0, busy}, 32'h1);
        check("run0_wr", {31'd0, wr_bank_sel}, 32'h0);
        spur_mask = 4'b0100;
        repeat (5) tick();
        check("spurious_en", {28'd0, layer_en}, 32'h1);
        check("spurious_cur", {29'd0, cur_layer}, 32'h0);
        spur_mask = 4'b0000;
        for (int i = 1; i < 4; i++) begin
            wait_en(4'(1 << i), 300);
            check("layer_cur", {29'd0, cur_layer}, 32'(i));
            check("layer_wr", {31'd0, wr_bank_sel}, 32'(i % 2));
            check("layer_rd", {31'd0, rd_bank_sel}, 32'((i + 1) % 2));
        end
        n = 0;
        while (done !== 1'b1 && n < 300) begin tick(); n++; end
        check("run_done", {31'd0, done}, 32'h1);
        check("run_cnt", {8'd0, cycle_cnt}, 32'd420);
        check("run_busy_fall", {31'd0, busy}, 32'h0);
        check("run_cur_hold", {29'd0, cur_layer}, 32'h3);
        tick();
        check("done_single", {31'd0, done}, 32'h0);
        repeat (5) tick();
        check("done_pulses", 32'(done_pulses), 32'd1);
        check("cnt_frozen", {8'd0, cycle_cnt}, 32'd420);

        // Abort at cycle 50 of layer 1
        pulse_start();
        wait_en(4'b0010, 300);
        repeat (50) tick();
        pulses_before = done_pulses;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_en", {28'd0, layer_en}, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'h0);
        check("abort_cnt", {8'd0, cycle_cnt}, 32'd156);
        repeat (5) tick();
        check("abort_no_done", 32'(done_pulses - pulses_before), 32'd0);

        // Fresh start after abort, start ignored mid-run
        pulse_start();
        check("restart_en", {28'd0, layer_en}, 32'h1);
        check("restart_cnt", {8'd0, cycle_cnt}, 32'h0);
        repeat (10) tick();
        pulse_start();
        check("midrun_start_en", {28'd0, layer_en}, 32'h1);
        check("midrun_start_cnt", {8'd0, cycle_cnt}, 32'd11);

        // Reset during layer 2
        wait_en(4'b0100, 400);
        rst = 1'b0;
        tick();
        check("mrst_en", {28'd0, layer_en}, 32'h0);
        check("mrst_cur", {29'd0, cur_layer}, 32'h0);
        check("mrst_banks", {30'd0, wr_bank_sel, rd_bank_sel}, 32'h1);
        check("mrst_busy", {31'd0, busy}, 32'h0);
        check("mrst_cnt", {8'd0, cycle_cnt}, 32'h0);
        rst = 1'b1;
        repeat (3) tick();

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("startabort_busy", {31'd0, busy}, 32'h0);
        check("startabort_en", {28'd0, layer_en}, 32'h0);

        // Wrapper never finishes
        hang = 1'b1;
        pulse_start();
        n = 0;
        while (layer_en[0] === 1'b1 && n < 300) begin n++; tick(); end
`ifdef SCHED_TIMEOUT_EN
        check("wd_en_cycles", 32'(n), 32'd64);
        check("wd_err", {31'd0, err}, 32'h1);
        check("wd_en_off", {28'd0, layer_en}, 32'h0);
        check("wd_busy", {31'd0, busy}, 32'h0);
        repeat (3) tick();
        check("wd_err_sticky", {31'd0, err}, 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("wd_abort_err", {31'd0, err}, 32'h0);
        check("wd_abort_busy", {31'd0, busy}, 32'h0);
`else
        check("nowd_en_cycles", 32'(n), 32'd300);
        check("nowd_err", {31'd0, err}, 32'h0);
        check("nowd_en", {28'd0, layer_en}, 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("nowd_abort_busy", {31'd0, busy}, 32'h0);
        check("nowd_abort_en", {28'd0, layer_en}, 32'h0);
`endif
        hang = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lenet_layer_scheduler.md
# lenet_layer_scheduler

Top-level sequencer for the LeNet-5 accelerator. It runs the layer wrappers in order (conv1+pool, conv2+pool, fc1, fc2) using each wrapper's level-enable/level-done handshake, and drives the ping-pong feature-map bank selects so that each layer reads its predecessor's output. It reports busy, done, error and total run cycles to the host.

## Interface
- N_LAYERS, 4, number of sequenced layer wrappers (≤ 8)
- GAP_CYCLES, 2, idle cycles between one layer's release and the next layer's enable (≥ 1)
- CNT_W, 24, run-cycle counter width
- TIMEOUT_CYCLES, 20000, per-layer watchdog limit (used only under SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all logic is rising-edge
- rst  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to begin a run; sampled only in IDLE
- abort  in  1  cancels the run from any state
- layer_en  out  N_LAYERS  one-hot level enable to the layer wrappers
- layer_done  in  N_LAYERS  level done from each wrapper; high while the wrapper sits in its DONE state
- cur_layer  out  3  index of the active or most recent layer
- wr_bank_sel  out  1  feature-map bank written by the current layer
- rd_bank_sel  out  1  feature-map bank read by the current layer
- busy  out  1  high from RUN entry through the last GAP
- done  out  1  one-cycle pulse on run completion
- err  out  1  sticky watchdog error
- cycle_cnt  out  CNT_W  cycles spent busy in the last or current run

## Operation
- States: IDLE, RUN, RELEASE, GAP, FINISH, ERROR.
- IDLE:
  - start=1 and abort=0 → RUN with cur_layer=0.
  - cycle_cnt clears on this transition.
- RUN:
  - layer_en[cur_layer]=1; all other enable bits are 0.
  - layer_done[cur_layer]=1 → RELEASE.
  - layer_done bits of non-current layers are ignored.
- RELEASE:
  - layer_en is all 0.
  - Waits for layer_done[cur_layer]=0 (the wrapper has returned to IDLE), then → GAP with the gap counter loaded to GAP_CYCLES-1.
- GAP:
  - Counts down. At 0: if cur_layer=N_LAYERS-1 → FINISH; otherwise cur_layer+1 → RUN.
- FINISH: done=1 for one cycle → IDLE. cur_layer holds its last value.
- Bank selects: wr_bank_sel=cur_layer[0] and rd_bank_sel=~cur_layer[0], both registered with cur_layer. Layer 0 reads image memory, so its rd_bank_sel is don't-care.
- cycle_cnt:
  - Increments every cycle busy=1.
  - Saturates at all-ones.
  - Frozen outside a run; the last run's value stays readable.
- abort=1 in any non-IDLE state → IDLE on the next edge: layer_en all 0, busy 0, no done pulse, err cleared.
- abort has priority over start, layer_done and timeout in the same cycle.
- start while not in IDLE is ignored.
- Reset (rst=0): state IDLE, layer_en 0, cur_layer 0, bank selects 0/1, busy 0, done 0, err 0, cycle_cnt 0. A reset mid-run drops layer_en on the same edge.

## Timing
- start at edge t → layer_en[0]=1 and busy=1 after edge t+1.
- layer_done high sampled at edge t → layer_en low after edge t.
- Wrapper deasserts done at edge t+1 (its FSM leaves DONE when en=0). The scheduler sees it at edge t+2 and enters GAP.
- The next layer_en rises GAP_CYCLES cycles after GAP entry.
- Fixed inter-layer overhead: 2+GAP_CYCLES cycles.
- done rises one cycle after the last GAP ends; busy falls on the same edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SCHED_TIMEOUT_EN defined:
  - A per-layer watchdog clears on each RUN entry and counts while in RUN.
  - Reaching TIMEOUT_CYCLES with no layer_done → ERROR on the next edge: layer_en 0, busy 0, err=1.
  - ERROR is left only via abort or reset.
- SCHED_TIMEOUT_EN undefined: no counter logic, err tied to 0, ERROR unreachable.

## Structure
- Shared package lenet_pkg holds:
  - the state enumeration (one-hot, 6 bits);
  - N_LAYERS;
  - layer index constants L_CONV1, L_CONV2, L_FC1, L_FC2.
- One sub-module, lenet_layer_watchdog (counter plus compare, timeout output), instantiated only under SCHED_TIMEOUT_EN.
- The FSM, gap counter, bank logic and cycle counter stay in the top module.

## Test plan
- Nominal run: wrapper models assert done 100 cycles after en rises. Required: en bits 0→3 in order, wr_bank_sel 0,1,0,1, a single done pulse, cycle_cnt = 4×100 + 4×(2+GAP_CYCLES) ± handshake cycles, checked exactly against the model.
- Spurious done: layer_done[2]=1 while layer 0 runs → no transition; layer_en stays 4'b0001.
- Abort at cycle 50 of layer 1 → layer_en 0 next edge, busy 0, no done; a fresh start then runs from layer 0.
- Ignored start: start asserted mid-run and start+abort together in IDLE → neither changes state.
- Reset mid-run: rst=0 during layer 2 → all outputs at reset values after one edge.
- Watchdog (macro on, TIMEOUT_CYCLES=64): wrapper never asserts done → err=1 and en 0 at cycle 64 of RUN; abort clears err and returns to IDLE. With the macro off, err stays 0.
